// File: rtl/iiitb_gc_pkg.sv
// Shared constants and Gray-code helpers for the iiitb_gc counter.
package iiitb_gc_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // Binary to Gray: each Gray bit is the XOR of adjacent binary bits; MSB passes through.
  function automatic logic [DEFAULT_WIDTH-1:0] bin2gray(input logic [DEFAULT_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: prefix XOR running down from the MSB.
  function automatic logic [DEFAULT_WIDTH-1:0] gray2bin(input logic [DEFAULT_WIDTH-1:0] gray);
    logic [DEFAULT_WIDTH-1:0] bin;
    bin[DEFAULT_WIDTH-1] = gray[DEFAULT_WIDTH-1];
    for (int i = DEFAULT_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/iiitb_gc_bin2gray.sv
// Purely combinational binary-to-Gray converter of arbitrary width.
module iiitb_gc_bin2gray #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Logical shift keeps the Gray MSB equal to the binary MSB.
  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/iiitb_gc.sv
// Enable-gated free-running Gray-code up-counter with a registered Gray output.
// The Gray value is derived from the next binary count so both registers
// update on the same edge with no extra latency.
module iiitb_gc
  import iiitb_gc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             enable,
  input  logic             reset,
  output logic [WIDTH-1:0] gray_count
);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;

  // Increment wraps naturally at 2^WIDTH through truncation.
  assign bin_next = bin_q + WIDTH'(1);

  iiitb_gc_bin2gray #(
    .WIDTH (WIDTH)
  ) u_bin2gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // Reset wins over enable; with enable low both registers hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q      <= '0;
      gray_count <= '0;
    end else if (enable) begin
      bin_q      <= bin_next;
      gray_count <= gray_next;
    end
  end

endmodule

// File: tb/tb_iiitb_gc.sv
// Self-checking bench for iiitb_gc (WIDTH=8): directed vector table, explicit
// wrap sequence, and a randomized run against an integer-count reference model.
module tb_iiitb_gc;
  import iiitb_gc_pkg::*;

  logic       clk;
  logic       enable;
  logic       reset;
  logic [7:0] gray_count;

  int total;
  int bad;
  int model_cnt;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] exp;
    string      name;
  } vec_t;

  iiitb_gc #(
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .enable     (enable),
    .reset      (reset),
    .gray_count (gray_count)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs, let one posedge happen, sample 1 ns later.
  task automatic step(input logic r, input logic e);
    reset  = r;
    enable = e;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer count, Gray defined as n ^ (n/2).
  function automatic logic [7:0] model_gray(input int n);
    return 8'(n ^ (n / 2));
  endfunction

  vec_t vecs[$];

  initial begin
    logic [7:0] prev;
    logic       r;
    logic       e;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    enable = 1'b1;

    // Directed table: reset, first 8 counts, hold, reset mid-count.
    vecs.push_back('{1'b1, 1'b1, 8'h00, "reset"});
    vecs.push_back('{1'b0, 1'b1, 8'h01, "seq1"});
    vecs.push_back('{1'b0, 1'b1, 8'h03, "seq2"});
    vecs.push_back('{1'b0, 1'b1, 8'h02, "seq3"});
    vecs.push_back('{1'b0, 1'b1, 8'h06, "seq4"});
    vecs.push_back('{1'b0, 1'b1, 8'h07, "seq5"});
    vecs.push_back('{1'b0, 1'b1, 8'h05, "seq6"});
    vecs.push_back('{1'b0, 1'b1, 8'h04, "seq7"});
    vecs.push_back('{1'b0, 1'b1, 8'h0C, "seq8"});
    vecs.push_back('{1'b1, 1'b0, 8'h00, "reset_noen"});
    vecs.push_back('{1'b0, 1'b1, 8'h01, "cnt1"});
    vecs.push_back('{1'b0, 1'b1, 8'h03, "cnt2"});
    vecs.push_back('{1'b0, 1'b1, 8'h02, "cnt3"});
    vecs.push_back('{1'b0, 1'b1, 8'h06, "cnt4"});
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 1'b0, 8'h06, "hold"});
    vecs.push_back('{1'b0, 1'b1, 8'h07, "reenable"});
    vecs.push_back('{1'b0, 1'b1, 8'h05, "cnt6"});
    vecs.push_back('{1'b1, 1'b1, 8'h00, "mid_reset"});
    vecs.push_back('{1'b0, 1'b1, 8'h01, "after_reset"});
    vecs.push_back('{1'b0, 1'b0, 8'h01, "hold_after"});
    vecs.push_back('{1'b0, 1'b1, 8'h03, "resume"});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en);
      check(vecs[i].name, gray_count, vecs[i].exp);
    end

    // Wrap sequence: 255 edges from 0 reach 8'h80, the 256th returns to 0.
    step(1'b1, 1'b1);
    check("wrap_reset", gray_count, 8'h00);
    for (int i = 0; i < 255; i++) step(1'b0, 1'b1);
    check("wrap_top", gray_count, 8'h80);
    step(1'b0, 1'b1);
    check("wrap_zero", gray_count, 8'h00);
    step(1'b0, 1'b1);
    check("wrap_next", gray_count, 8'h01);

    // Randomized run against the integer model, several wraps deep.
    step(1'b1, 1'b0);
    model_cnt = 0;
    check("rand_reset", gray_count, 8'h00);
    for (int i = 0; i < 1200; i++) begin
      prev = gray_count;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 7) != 0);
      step(r, e);
      if (r) model_cnt = 0;
      else if (e) model_cnt = (model_cnt + 1) % 256;
      check("rand_model", gray_count, model_gray(model_cnt));
      if (!r && e) begin
        check("rand_onebit", $countones(prev ^ gray_count), 1);
        check("rand_g2b", gray2bin(gray_count), 8'(gray2bin(prev) + 8'd1));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
